atm_core: RTL and testbench

ATM_CORE -- requirements
Module: atm_core

---
 rtl/atm_pkg.sv | 49 ++++
 rtl/atm_account_bank.sv | 62 ++++++
 rtl/atm_core.sv | 207 ++++++++++++++++++++
 tb/tb_atm_core.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared encodings for the ATM core: opcodes, FSM states, error codes and
// the factory PIN table.
package atm_pkg;

  localparam logic [2:0] OP_WITHDRAW = 3'd1;
  localparam logic [2:0] OP_BALANCE  = 3'd3;
  localparam logic [2:0] OP_DEPOSIT  = 3'd5;
  localparam logic [2:0] OP_CHPIN    = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_MENU     = 3'd2,
    ST_BALANCE  = 3'd3,
    ST_WITHDRAW = 3'd4,
    ST_DEPOSIT  = 3'd5,
    ST_CHPIN    = 3'd6,
    ST_REPORT   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_BAD_ACC  = 3'd1,
    ERR_BAD_PIN  = 3'd2,
    ERR_LOCKED   = 3'd3,
    ERR_FUNDS    = 3'd4,
    ERR_OVERFLOW = 3'd5,
    ERR_OPCODE   = 3'd6
  } err_e;

  // Factory PIN for account number acc (1-based); the table repeats every 10.
  function automatic logic [15:0] default_pin(input int unsigned acc);
    logic [15:0] p;
    case ((acc - 1) % 10)
      0:       p = 16'd1234;
      1:       p = 16'd2345;
      2:       p = 16'd3456;
      3:       p = 16'd4567;
      4:       p = 16'd5678;
      5:       p = 16'd6789;
      6:       p = 16'd7890;
      7:       p = 16'd8901;
      8:       p = 16'd9012;
      default: p = 16'd7123;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/atm_account_bank.sv
// Per-account storage: balance, PIN and consecutive-failure count.
// One combinational read port, one synchronous whole-record write port.
module atm_account_bank
  import atm_pkg::*;
#(
  parameter int unsigned N_ACC     = 10,
  parameter int unsigned ACC_W     = 4,
  parameter int unsigned AMT_W     = 16,
  parameter int unsigned PIN_W     = 16,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned INIT_BAL  = 1000,
  parameter int unsigned FAIL_W    = $clog2(MAX_TRIES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ACC_W-1:0]  rd_acc_i,
  output logic [AMT_W-1:0]  rd_bal_o,
  output logic [PIN_W-1:0]  rd_pin_o,
  output logic [FAIL_W-1:0] rd_fail_o,
  input  logic              we_i,
  input  logic [ACC_W-1:0]  wr_acc_i,
  input  logic [AMT_W-1:0]  wr_bal_i,
  input  logic [PIN_W-1:0]  wr_pin_i,
  input  logic [FAIL_W-1:0] wr_fail_i
);

  logic [AMT_W-1:0]  bal_q  [1:N_ACC];
  logic [PIN_W-1:0]  pin_q  [1:N_ACC];
  logic [FAIL_W-1:0] fail_q [1:N_ACC];

  logic rd_ok, wr_ok;
  assign rd_ok = (rd_acc_i != '0) && (rd_acc_i <= ACC_W'(N_ACC));
  assign wr_ok = (wr_acc_i != '0) && (wr_acc_i <= ACC_W'(N_ACC));

  // Read port: out-of-range account numbers read as all zeros.
  always_comb begin
    rd_bal_o  = '0;
    rd_pin_o  = '0;
    rd_fail_o = '0;
    if (rd_ok) begin
      rd_bal_o  = bal_q[rd_acc_i];
      rd_pin_o  = pin_q[rd_acc_i];
      rd_fail_o = fail_q[rd_acc_i];
    end
  end

  // Record storage: reset restores factory balances and PINs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 1; i <= N_ACC; i++) begin
        bal_q[i]  <= AMT_W'(INIT_BAL);
        pin_q[i]  <= PIN_W'(default_pin(i));
        fail_q[i] <= '0;
      end
    end else if (we_i && wr_ok) begin
      bal_q[wr_acc_i]  <= wr_bal_i;
      pin_q[wr_acc_i]  <= wr_pin_i;
      fail_q[wr_acc_i] <= wr_fail_i;
    end
  end

endmodule

// File: rtl/atm_core.sv
// ATM transaction core: accepts one request at a time, authenticates it
// against the account bank, performs the operation and reports the result.
module atm_core
  import atm_pkg::*;
#(
  parameter int unsigned N_ACC     = 10,
  parameter int unsigned ACC_W     = 4,
  parameter int unsigned AMT_W     = 16,
  parameter int unsigned PIN_W     = 16,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned INIT_BAL  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       operation,
  input  logic [ACC_W-1:0] acc_num,
  input  logic [PIN_W-1:0] pin,
  input  logic [PIN_W-1:0] newPin,
  input  logic [AMT_W-1:0] amount,
  input  logic             language,
  output logic [AMT_W-1:0] balance,
  output logic             success,
  output logic             done,
  output logic [2:0]       err,
  output logic             lang_out,
  output logic [2:0]       state
);

  localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);

  state_e           state_q;
  logic [2:0]       op_q;
  logic [ACC_W-1:0] acc_q;
  logic [PIN_W-1:0] pin_q, newpin_q;
  logic [AMT_W-1:0] amt_q, balance_q;
  logic             lang_q, success_q, done_q, res_ok_q;
  err_e             err_q, res_err_q;

  logic [AMT_W-1:0]  rd_bal, wr_bal;
  logic [PIN_W-1:0]  rd_pin, wr_pin;
  logic [FAIL_W-1:0] rd_fail, wr_fail;
  logic              we;
  logic              acc_bad, locked, pin_ok, funds_short;
  logic [AMT_W:0]    sum;

  atm_account_bank #(
    .N_ACC     (N_ACC),
    .ACC_W     (ACC_W),
    .AMT_W     (AMT_W),
    .PIN_W     (PIN_W),
    .MAX_TRIES (MAX_TRIES),
    .INIT_BAL  (INIT_BAL),
    .FAIL_W    (FAIL_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .rd_acc_i  (acc_q),
    .rd_bal_o  (rd_bal),
    .rd_pin_o  (rd_pin),
    .rd_fail_o (rd_fail),
    .we_i      (we),
    .wr_acc_i  (acc_q),
    .wr_bal_i  (wr_bal),
    .wr_pin_i  (wr_pin),
    .wr_fail_i (wr_fail)
  );

  assign acc_bad     = (acc_q == '0) || (acc_q > ACC_W'(N_ACC));
  assign locked      = (rd_fail == FAIL_W'(MAX_TRIES));
  assign pin_ok      = (pin_q == rd_pin);
  assign funds_short = (amt_q > rd_bal);
  assign sum         = {1'b0, rd_bal} + {1'b0, amt_q};

  // Bank write-back: read-modify-write of the selected record, committed on
  // the edge that leaves CHECK or an operation state.
  always_comb begin
    we      = 1'b0;
    wr_bal  = rd_bal;
    wr_pin  = rd_pin;
    wr_fail = rd_fail;
    case (state_q)
      ST_CHECK: begin
        if (!acc_bad && !locked) begin
          we      = 1'b1;
          wr_fail = pin_ok ? '0 : rd_fail + 1'b1;
        end
      end
      ST_WITHDRAW: begin
        we     = !funds_short;
        wr_bal = rd_bal - amt_q;
      end
      ST_DEPOSIT: begin
        we     = !sum[AMT_W];
        wr_bal = sum[AMT_W-1:0];
      end
      ST_CHPIN: begin
        we     = 1'b1;
        wr_pin = newpin_q;
      end
      default: ;
    endcase
  end

  // Transaction FSM; the result is staged in res_*_q and published in REPORT
  // so success/err stay stable between reports.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      acc_q     <= '0;
      pin_q     <= '0;
      newpin_q  <= '0;
      amt_q     <= '0;
      lang_q    <= 1'b0;
      balance_q <= '0;
      success_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= ERR_NONE;
      res_ok_q  <= 1'b0;
      res_err_q <= ERR_NONE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q     <= operation;
            acc_q    <= acc_num;
            pin_q    <= pin;
            newpin_q <= newPin;
            amt_q    <= amount;
            lang_q   <= language;
            state_q  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          res_ok_q <= 1'b0;
          if (acc_bad) begin
            res_err_q <= ERR_BAD_ACC;
            state_q   <= ST_REPORT;
          end else if (locked) begin
            res_err_q <= ERR_LOCKED;
            state_q   <= ST_REPORT;
          end else if (!pin_ok) begin
            res_err_q <= ERR_BAD_PIN;
            state_q   <= ST_REPORT;
          end else begin
            res_err_q <= ERR_NONE;
            balance_q <= rd_bal;
            state_q   <= ST_MENU;
          end
        end
        ST_MENU: begin
          case (op_q)
            OP_BALANCE:  state_q <= ST_BALANCE;
            OP_WITHDRAW: state_q <= ST_WITHDRAW;
            OP_DEPOSIT:  state_q <= ST_DEPOSIT;
            OP_CHPIN:    state_q <= ST_CHPIN;
            default: begin
              res_err_q <= ERR_OPCODE;
              state_q   <= ST_REPORT;
            end
          endcase
        end
        ST_BALANCE, ST_CHPIN: begin
          res_ok_q <= 1'b1;
          state_q  <= ST_REPORT;
        end
        ST_WITHDRAW: begin
          if (funds_short) begin
            res_err_q <= ERR_FUNDS;
          end else begin
            res_ok_q  <= 1'b1;
            balance_q <= rd_bal - amt_q;
          end
          state_q <= ST_REPORT;
        end
        ST_DEPOSIT: begin
          if (sum[AMT_W]) begin
            res_err_q <= ERR_OVERFLOW;
          end else begin
            res_ok_q  <= 1'b1;
            balance_q <= sum[AMT_W-1:0];
          end
          state_q <= ST_REPORT;
        end
        ST_REPORT: begin
          success_q <= res_ok_q;
          err_q     <= res_err_q;
          done_q    <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign balance   = balance_q;
  assign success   = success_q;
  assign done      = done_q;
  assign err       = err_q;
  assign lang_out  = lang_q;
  assign state     = state_q;

endmodule

// File: tb/tb_atm_core.sv
// Directed-vector bench for atm_core.
module tb_atm_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  operation = '0;
  logic [3:0]  acc_num = '0;
  logic [15:0] pin = '0;
  logic [15:0] newPin = '0;
  logic [15:0] amount = '0;
  logic        language = 1'b0;
  logic [15:0] balance;
  logic        success;
  logic        done;
  logic [2:0]  err;
  logic        lang_out;
  logic [2:0]  state;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned lat;

  always #5 clk = ~clk;

  atm_core #(
    .N_ACC     (10),
    .ACC_W     (4),
    .AMT_W     (16),
    .PIN_W     (16),
    .MAX_TRIES (3),
    .INIT_BAL  (1000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .operation (operation),
    .acc_num   (acc_num),
    .pin       (pin),
    .newPin    (newPin),
    .amount    (amount),
    .language  (language),
    .balance   (balance),
    .success   (success),
    .done      (done),
    .err       (err),
    .lang_out  (lang_out),
    .state     (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for done; returns cycles from
  // the accepting edge to the edge that raised done.
  task automatic do_req(input logic [2:0] op, input logic [3:0] acc,
                        input logic [15:0] p, input logic [15:0] np,
                        input logic [15:0] amt, input logic lang,
                        output int unsigned cycles);
    @(negedge clk);
    operation = op; acc_num = acc; pin = p; newPin = np;
    amount = amt; language = lang; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cycles = 0;
    while (1) begin
      @(posedge clk);
      #1 cycles++;
      if (done) break;
      if (cycles >= 20) begin
        chk("done_timeout", 0, 1);
        break;
      end
    end
  endtask

  initial begin
    #12;
    // Reset state
    chk("rst_state", state, 0);
    chk("rst_done", done, 0);
    chk("rst_success", success, 0);
    chk("rst_err", err, 0);
    chk("rst_balance", balance, 0);
    chk("rst_lang", lang_out, 0);
    chk("rst_ready", req_ready, 1);
    @(negedge clk) rst = 1'b1;

    // Balance enquiry, Arabic
    do_req(3'd3, 4'd1, 16'd1234, 16'd0, 16'd0, 1'b1, lat);
    chk("bal_lat", lat, 4);
    chk("bal_success", success, 1);
    chk("bal_err", err, 0);
    chk("bal_balance", balance, 1000);
    chk("bal_lang", lang_out, 1);
    chk("bal_state", state, 0);
    @(posedge clk) #1 chk("done_pulse_width", done, 0);

    // Deposit then enquiry
    do_req(3'd5, 4'd1, 16'd1234, 16'd0, 16'd1000, 1'b0, lat);
    chk("dep_balance", balance, 2000);
    chk("dep_success", success, 1);
    chk("dep_lang", lang_out, 0);
    do_req(3'd3, 4'd1, 16'd1234, 16'd0, 16'd0, 1'b0, lat);
    chk("dep_bal2", balance, 2000);

    // Lockout on account 2
    for (int i = 0; i < 3; i++) begin
      do_req(3'd3, 4'd2, 16'd9999, 16'd0, 16'd0, 1'b0, lat);
      chk("wrongpin_err", err, 2);
      chk("wrongpin_lat", lat, 2);
      chk("wrongpin_success", success, 0);
    end
    do_req(3'd3, 4'd2, 16'd2345, 16'd0, 16'd0, 1'b0, lat);
    chk("locked_err", err, 3);
    chk("locked_success", success, 0);
    chk("locked_bal_held", balance, 2000);
    do_req(3'd3, 4'd2, 16'd1, 16'd0, 16'd0, 1'b0, lat);
    chk("locked_wrong_err", err, 3);
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    do_req(3'd3, 4'd2, 16'd2345, 16'd0, 16'd0, 1'b0, lat);
    chk("unlock_success", success, 1);
    chk("unlock_balance", balance, 1000);

    // Funds boundaries on account 3
    do_req(3'd1, 4'd3, 16'd3456, 16'd0, 16'd1001, 1'b0, lat);
    chk("wd_short_err", err, 4);
    chk("wd_short_success", success, 0);
    chk("wd_short_balance", balance, 1000);
    do_req(3'd5, 4'd3, 16'd3456, 16'd0, 16'd65000, 1'b0, lat);
    chk("dep_ovf_err", err, 5);
    chk("dep_ovf_balance", balance, 1000);
    do_req(3'd1, 4'd3, 16'd3456, 16'd0, 16'd1000, 1'b0, lat);
    chk("wd_exact_success", success, 1);
    chk("wd_exact_balance", balance, 0);
    do_req(3'd5, 4'd3, 16'd3456, 16'd0, 16'd0, 1'b0, lat);
    chk("dep_zero_success", success, 1);
    chk("dep_zero_balance", balance, 0);
    do_req(3'd5, 4'd3, 16'd3456, 16'd0, 16'd65535, 1'b0, lat);
    chk("dep_max_success", success, 1);
    chk("dep_max_balance", balance, 65535);
    do_req(3'd5, 4'd3, 16'd3456, 16'd0, 16'd1, 1'b0, lat);
    chk("dep_carry_err", err, 5);
    do_req(3'd1, 4'd3, 16'd3456, 16'd0, 16'd0, 1'b0, lat);
    chk("wd_zero_balance", balance, 65535);
    chk("wd_zero_success", success, 1);

    // PIN change on account 4, bad accounts
    do_req(3'd6, 4'd4, 16'd4567, 16'd1111, 16'd0, 1'b0, lat);
    chk("chpin_success", success, 1);
    chk("chpin_lat", lat, 4);
    do_req(3'd3, 4'd4, 16'd4567, 16'd0, 16'd0, 1'b0, lat);
    chk("oldpin_err", err, 2);
    do_req(3'd3, 4'd4, 16'd1111, 16'd0, 16'd0, 1'b0, lat);
    chk("newpin_success", success, 1);
    chk("newpin_err", err, 0);
    do_req(3'd3, 4'd11, 16'd1234, 16'd0, 16'd0, 1'b0, lat);
    chk("acc11_err", err, 1);
    chk("acc11_lat", lat, 2);
    do_req(3'd3, 4'd0, 16'd1234, 16'd0, 16'd0, 1'b0, lat);
    chk("acc0_err", err, 1);
    do_req(3'd3, 4'd10, 16'd7123, 16'd0, 16'd0, 1'b0, lat);
    chk("acc10_success", success, 1);

    // Illegal opcode
    do_req(3'd2, 4'd5, 16'd5678, 16'd0, 16'd0, 1'b0, lat);
    chk("illop_err", err, 6);
    chk("illop_success", success, 0);

    // Reset while in MENU of a deposit
    @(negedge clk);
    operation = 3'd5; acc_num = 4'd5; pin = 16'd5678; amount = 16'd500; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 chk("abort_in_menu", state, 2);
    #2 rst = 1'b0;
    #1 chk("abort_state", state, 0);
    chk("abort_done", done, 0);
    @(negedge clk) rst = 1'b1;
    begin
      int unsigned seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk) #1 if (done) seen++;
      end
      chk("abort_no_done", seen, 0);
    end
    do_req(3'd3, 4'd5, 16'd5678, 16'd0, 16'd0, 1'b0, lat);
    chk("abort_bank_bal", balance, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0, expected 1");
    $fatal(1, "timeout");
  end

endmodule
